// File: rtl/ifetch_queue.sv
// Fetch prefetch queue between a variable-latency imem and the IF/ID register.
// Define IFQ_BYPASS_EN for zero-cycle response-to-output forwarding.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    output logic        o_imem_req_vld,
    output logic [31:0] o_imem_req_addr,
    input  logic        i_imem_req_rdy,
    input  logic        i_imem_rsp_vld,
    input  logic [31:0] i_imem_rsp_data,
    output logic        o_fetch_vld,
    output logic [31:0] o_fetch_pc,
    output logic [31:0] o_fetch_instr,
    input  logic        i_fetch_rdy,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [31:0]    pc_q    [DEPTH];
    logic [31:0]    instr_q [DEPTH];
    logic [DEPTH-1:0] filled;
    logic [AW-1:0]  head, fill, tail;
    logic [CW-1:0]  count, pend, drop;
    logic [31:0]    fetch_pc;

    logic full, issue, take, pop, byp, head_vld;

    assign full = (count == FULL_CNT);
    // responses owed to a pre-redirect stream are swallowed here
    assign take = i_imem_rsp_vld && (drop == '0);

`ifdef IFQ_BYPASS_EN
    assign byp = take && !filled[head] && (head == fill);
`else
    assign byp = 1'b0;
`endif

    assign head_vld        = filled[head] || byp;
    assign o_imem_req_vld  = !full && !i_redirect && i_reset;
    assign o_imem_req_addr = fetch_pc;
    assign o_fetch_vld     = head_vld && !i_redirect && i_reset;
    assign o_fetch_pc      = i_reset ? pc_q[head] : '0;
    assign o_busy          = i_reset && ((count != '0) || (drop != '0));

    always_comb begin
        o_fetch_instr = '0;
        if (i_reset)
            o_fetch_instr = byp ? i_imem_rsp_data : instr_q[head];
    end

    assign issue = o_imem_req_vld && i_imem_req_rdy;
    assign pop   = o_fetch_vld && i_fetch_rdy;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            head     <= '0;
            fill     <= '0;
            tail     <= '0;
            count    <= '0;
            pend     <= '0;
            drop     <= '0;
            filled   <= '0;
            fetch_pc <= RESET_PC;
        end else if (i_redirect) begin
            head     <= '0;
            fill     <= '0;
            tail     <= '0;
            count    <= '0;
            pend     <= '0;
            filled   <= '0;
            fetch_pc <= i_redirect_pc & 32'hFFFF_FFFC;
            drop     <= drop + pend - CW'(i_imem_rsp_vld);
        end else begin
            if (issue) begin
                pc_q[tail]   <= fetch_pc;
                filled[tail] <= 1'b0;
                tail         <= tail + AW'(1);
                fetch_pc     <= fetch_pc + 32'd4;
            end
            if (i_imem_rsp_vld && (drop != '0))
                drop <= drop - CW'(1);
            if (take) begin
                instr_q[fill] <= i_imem_rsp_data;
                fill          <= fill + AW'(1);
                // a bypassed word consumed this cycle never lands as filled
                if (!(byp && pop))
                    filled[fill] <= 1'b1;
            end
            if (pop) begin
                filled[head] <= 1'b0;
                head         <= head + AW'(1);
            end
            count <= count + CW'(issue) - CW'(pop);
            pend  <= pend + CW'(issue) - CW'(take);
        end
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// Randomized scoreboard bench for ifetch_queue with an in-order memory model.
// Expected stream: consecutive words from the last restart PC, each with data_of(pc).
module tb_ifetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        i_clk;
    logic        i_reset;
    logic        o_imem_req_vld;
    logic [31:0] o_imem_req_addr;
    logic        i_imem_req_rdy;
    logic        i_imem_rsp_vld;
    logic [31:0] i_imem_rsp_data;
    logic        o_fetch_vld;
    logic [31:0] o_fetch_pc;
    logic [31:0] o_fetch_instr;
    logic        i_fetch_rdy;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_busy;

    ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .o_imem_req_vld  (o_imem_req_vld),
        .o_imem_req_addr (o_imem_req_addr),
        .i_imem_req_rdy  (i_imem_req_rdy),
        .i_imem_rsp_vld  (i_imem_rsp_vld),
        .i_imem_rsp_data (i_imem_rsp_data),
        .o_fetch_vld     (o_fetch_vld),
        .o_fetch_pc      (o_fetch_pc),
        .o_fetch_instr   (o_fetch_instr),
        .i_fetch_rdy     (i_fetch_rdy),
        .i_redirect      (i_redirect),
        .i_redirect_pc   (i_redirect_pc),
        .o_busy          (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] pc;
        bit          arrived;
    } sb_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } mem_t;

    sb_t         sb[$];
    mem_t        mq[$];
    logic [31:0] exp_pc;
    int          cyc;
    int          tests;
    int          fails;

    function automatic logic [31:0] data_of(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    // monitor: compare outputs mid-cycle, then retire responses and pops
    always @(negedge i_clk) begin : mon
        int nstale;
        bit byp;
        bit e_vld;
        nstale = 0;
        foreach (mq[i]) if (mq[i].stale) nstale++;
        if (!i_reset) begin
            chk("rst_req_vld", 32'(o_imem_req_vld), 32'd0);
            chk("rst_fetch_vld", 32'(o_fetch_vld), 32'd0);
            chk("rst_busy", 32'(o_busy), 32'd0);
            chk("rst_fetch_pc", o_fetch_pc, 32'd0);
            chk("rst_fetch_instr", o_fetch_instr, 32'd0);
        end else begin
            byp = 1'b0;
`ifdef IFQ_BYPASS_EN
            if (i_imem_rsp_vld && mq.size() > 0 && !mq[0].stale &&
                sb.size() > 0 && !sb[0].arrived)
                byp = 1'b1;
`endif
            e_vld = sb.size() > 0 && (sb[0].arrived || byp) && !i_redirect;
            chk("req_vld", 32'(o_imem_req_vld),
                32'(sb.size() < DEPTH && !i_redirect));
            if (o_imem_req_vld)
                chk("req_addr", o_imem_req_addr, exp_pc);
            chk("fetch_vld", 32'(o_fetch_vld), 32'(e_vld));
            chk("busy", 32'(o_busy), 32'(sb.size() != 0 || nstale != 0));
            if (e_vld && o_fetch_vld) begin
                chk("fetch_pc", o_fetch_pc, sb[0].pc);
                chk("fetch_instr", o_fetch_instr, data_of(sb[0].pc));
            end
            if (i_imem_rsp_vld && mq.size() > 0) begin
                if (!mq[0].stale) begin
                    for (int i = 0; i < sb.size(); i++) begin
                        if (!sb[i].arrived) begin
                            sb[i].arrived = 1'b1;
                            break;
                        end
                    end
                end
                void'(mq.pop_front());
            end
            if (e_vld && i_fetch_rdy)
                void'(sb.pop_front());
        end
    end

    // stimulus: drive after posedge, book issues/redirects after the monitor
    initial begin
        int phase;
        int lat;
        i_reset         = 1'b0;
        i_imem_req_rdy  = 1'b0;
        i_imem_rsp_vld  = 1'b0;
        i_imem_rsp_data = '0;
        i_fetch_rdy     = 1'b0;
        i_redirect      = 1'b0;
        i_redirect_pc   = '0;
        exp_pc          = RESET_PC;
        cyc             = 0;
        tests           = 0;
        fails           = 0;
        for (int c = 0; c < 4000; c++) begin
            @(posedge i_clk);
            #1;
            cyc++;
            phase = c / 1000;
            i_reset = !(c < 2 || (phase == 3 && $urandom_range(0, 120) == 0));
            i_imem_req_rdy = (phase == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (phase == 0)
                i_fetch_rdy = 1'b1;
            else if (phase == 1)
                i_fetch_rdy = ($urandom_range(0, 9) < 2);
            else
                i_fetch_rdy = ($urandom_range(0, 3) != 0);
            i_redirect = i_reset && phase >= 2 && mq.size() <= DEPTH &&
                         ($urandom_range(0, 12) == 0);
            if ($urandom_range(0, 7) == 0)
                i_redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else
                i_redirect_pc = $urandom;
            i_imem_rsp_vld = i_reset && mq.size() > 0 && mq[0].due <= cyc &&
                             (phase == 0 || $urandom_range(0, 3) != 0);
            i_imem_rsp_data = i_imem_rsp_vld ? data_of(mq[0].addr) : $urandom;
            @(negedge i_clk);
            #1;
            lat = (phase == 0) ? 1 : $urandom_range(1, 4);
            if (!i_reset) begin
                sb.delete();
                mq.delete();
                exp_pc = RESET_PC;
            end else if (i_redirect) begin
                sb.delete();
                foreach (mq[i]) mq[i].stale = 1'b1;
                exp_pc = i_redirect_pc & 32'hFFFF_FFFC;
            end else if (o_imem_req_vld && i_imem_req_rdy) begin
                sb.push_back('{pc: exp_pc, arrived: 1'b0});
                mq.push_back('{addr: exp_pc, due: cyc + lat, stale: 1'b0});
                exp_pc = exp_pc + 32'd4;
            end
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
